multicore_dm_arbiter: RTL and testbench

//  Shares one single-port synchronous data memory among N_CORES processor cores.

---
 rtl/multicore_dm_arbiter_if.sv | 36 +++
 rtl/multicore_dm_arbiter.sv | 121 ++++++++++++
 tb/tb_multicore_dm_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/multicore_dm_arbiter_if.sv
// rtl/multicore_dm_arbiter_if.sv - core/memory side bundle for the multi-core data-memory arbiter
interface multicore_dm_arbiter_if #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 17,
    parameter int CNT_W   = 32
);
    logic                        mem_ready;
    logic [N_CORES-1:0]          core_req;
    logic [N_CORES-1:0]          core_we;
    logic [N_CORES*ADDR_W-1:0]   core_addr;
    logic [N_CORES*DATA_W-1:0]   core_wdata;
    logic [N_CORES-1:0]          core_end;
    logic [N_CORES-1:0]          core_gnt;
    logic [N_CORES-1:0]          core_rvalid;
    logic [DATA_W-1:0]           core_rdata;
    logic                        core_start;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        all_done;
    logic [CNT_W-1:0]            run_cycles;

    modport slave (
        input  mem_ready, core_req, core_we, core_addr, core_wdata, core_end, mem_rdata,
        output core_gnt, core_rvalid, core_rdata, core_start, mem_we, mem_addr, mem_wdata,
               all_done, run_cycles
    );

    modport master (
        output mem_ready, core_req, core_we, core_addr, core_wdata, core_end, mem_rdata,
        input  core_gnt, core_rvalid, core_rdata, core_start, mem_we, mem_addr, mem_wdata,
               all_done, run_cycles
    );
endinterface

// File: rtl/multicore_dm_arbiter.sv
// rtl/multicore_dm_arbiter.sv - shares one sync data memory among N cores (MCARB_FIXED_PRIO_EN selects fixed priority)
module multicore_dm_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 17,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    multicore_dm_arbiter_if.slave     bus
);
    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [N_CORES-1:0] end_seen;
    logic [N_CORES-1:0] eligible;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic               read_in_flight;
    logic               run_complete;

    // A core whose grant is showing this cycle is still holding req; mask it out.
    assign eligible       = bus.core_req & ~bus.core_gnt;
    // A read granted this cycle has its data arriving next cycle.
    assign read_in_flight = (|bus.core_gnt) & ~bus.mem_we;
    assign run_complete   = (&end_seen) & ~read_in_flight;

    // Read data is only meaningful alongside an rvalid pulse; otherwise it reads as zero.
    assign bus.core_rdata = (|bus.core_rvalid) ? bus.mem_rdata : '0;

`ifndef MCARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_ptr;

    function automatic logic [IDX_W-1:0] rr_cand(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_CORES) s = s - N_CORES;
        return IDX_W'(s);
    endfunction

    // Round-robin pointer remembers the last winner; reset makes core 0 the first pick.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= IDX_W'(N_CORES - 1);
        end else if (state == RUN && !run_complete && win_found) begin
            rr_ptr <= win_idx;
        end
    end
`endif

    // Winner selection for the current cycle.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef MCARB_FIXED_PRIO_EN
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (eligible[IDX_W'(i)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
`else
        for (int k = 1; k <= N_CORES; k++) begin
            if (!win_found && eligible[rr_cand(rr_ptr, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_cand(rr_ptr, k);
            end
        end
`endif
    end

    // Control FSM with registered grant, memory command, rvalid and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bus.core_gnt    <= '0;
            bus.core_rvalid <= '0;
            bus.core_start  <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.all_done    <= 1'b0;
            bus.run_cycles  <= '0;
            end_seen        <= '0;
        end else begin
            bus.core_rvalid <= bus.core_gnt & {N_CORES{~bus.mem_we}};
            bus.core_gnt    <= '0;
            bus.mem_we      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mem_ready) begin
                        state          <= RUN;
                        bus.core_start <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.run_cycles != '1) bus.run_cycles <= bus.run_cycles + 1'b1;
                    end_seen <= end_seen | bus.core_end;
                    if (run_complete) begin
                        state          <= DONE;
                        bus.core_start <= 1'b0;
                        bus.all_done   <= 1'b1;
                    end else if (win_found) begin
                        bus.core_gnt  <= {{(N_CORES-1){1'b0}}, 1'b1} << win_idx;
                        bus.mem_we    <= bus.core_we[win_idx];
                        bus.mem_addr  <= bus.core_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                        bus.mem_wdata <= bus.core_wdata[int'(win_idx)*DATA_W +: DATA_W];
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicore_dm_arbiter.sv
// tb/tb_multicore_dm_arbiter.sv - table-driven bench for multicore_dm_arbiter
module tb_multicore_dm_arbiter;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 17;
    localparam int CW = 32;
    localparam logic [AW-1:0] WR_ADDR = 12'h005;
    localparam logic [DW-1:0] WR_DATA = 17'h1ABCD;

    typedef struct {
        logic          rst;
        logic          rdy;
        logic [N-1:0]  req;
        logic [N-1:0]  we;
        logic [N-1:0]  cend;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] wdata;
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_rvalid;
        logic [DW-1:0] e_rdata;
        logic          e_start;
        logic          e_done;
        logic          e_we;
        logic [CW-1:0] e_run;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   miscompares = 0;
    int   vi = 0;
    vec_t vecs[$];
    logic [N*AW-1:0] cur_addr;
    logic [N*DW-1:0] cur_wdata;
    logic [DW-1:0]   mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    multicore_dm_arbiter_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

    multicore_dm_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-port synchronous data memory with one cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return DW'(a) * 17'd7 + 17'd3;
    endfunction

    function automatic vec_t mk(input logic r, input logic rdy, input logic [N-1:0] req,
                                input logic [N-1:0] we, input logic [N-1:0] cend,
                                input logic [N-1:0] eg, input logic [N-1:0] erv,
                                input logic [DW-1:0] erd, input logic est, input logic edn,
                                input logic ewe, input int erun);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.req = req; v.we = we; v.cend = cend;
        v.addr = cur_addr; v.wdata = cur_wdata;
        v.e_gnt = eg; v.e_rvalid = erv; v.e_rdata = erd;
        v.e_start = est; v.e_done = edn; v.e_we = ewe; v.e_run = CW'(erun);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (vector %0d): got %0h, expected %0h", name, vi, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic [N-1:0] req,
                         input logic [N-1:0] we, input logic [N-1:0] cend);
        rst            = r;
        bus.mem_ready  = rdy;
        bus.core_req   = req;
        bus.core_we    = we;
        bus.core_end   = cend;
        bus.core_addr  = cur_addr;
        bus.core_wdata = cur_wdata;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n_vec++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = init_val(AW'(a));
        bus.mem_rdata = '0;
        cur_addr  = {12'h023, 12'h022, 12'h021, 12'h020};
        cur_wdata = '0;

        // reset, then IDLE ignores requests, then start
        vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 0, 0));
        // four simultaneous reads, granted in order, data one cycle later
        vecs.push_back(mk(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 4'b1110, 4'b0000, 4'b0000, 4'b0010, 4'b0001, init_val(12'h020), 1, 0, 0, 2));
        vecs.push_back(mk(0, 1, 4'b1100, 4'b0000, 4'b0000, 4'b0100, 4'b0010, init_val(12'h021), 1, 0, 0, 3));
        vecs.push_back(mk(0, 1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0100, init_val(12'h022), 1, 0, 0, 4));
        vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, init_val(12'h023), 1, 0, 0, 5));
        // core 2 writes, core 0 reads it back
        cur_addr  = {12'h023, WR_ADDR, 12'h021, WR_ADDR};
        cur_wdata = {17'h0, WR_DATA, 17'h0, 17'h0};
        vecs.push_back(mk(0, 1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 0, 1, 0, 1, 6));
        vecs.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 1, 0, 0, 7));
        vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, WR_DATA, 1, 0, 0, 8));
        cur_addr  = {12'h023, 12'h022, 12'h021, 12'h020};
        cur_wdata = '0;
        // core 0 hammering, core 3 once: core 3 still served
        vecs.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 1, 0, 0, 9));
        vecs.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, init_val(12'h020), 1, 0, 0, 10));
        vecs.push_back(mk(0, 1, 4'b1001, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 0, 1, 0, 0, 11));
        vecs.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b1000, init_val(12'h023), 1, 0, 0, 12));
        vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, init_val(12'h020), 1, 0, 0, 13));
        // end pulses 1,3,0,2 with a read in flight after the last one
        vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 0, 1, 0, 0, 14));
        vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 0, 1, 0, 0, 15));
        vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 1, 0, 0, 16));
        vecs.push_back(mk(0, 1, 4'b0010, 4'b0000, 4'b0100, 4'b0010, 4'b0000, 0, 1, 0, 0, 17));
        vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, init_val(12'h021), 1, 0, 0, 18));
        vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 19));
        vecs.push_back(mk(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 19));

        for (int i = 0; i < vecs.size(); i++) begin
            vi = i;
            cur_addr  = vecs[i].addr;
            cur_wdata = vecs[i].wdata;
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].req, vecs[i].we, vecs[i].cend);
            step();
            check("core_gnt",    64'(bus.core_gnt),    64'(vecs[i].e_gnt));
            check("core_rvalid", 64'(bus.core_rvalid), 64'(vecs[i].e_rvalid));
            if (vecs[i].e_rvalid != '0)
                check("core_rdata", 64'(bus.core_rdata), 64'(vecs[i].e_rdata));
            check("core_start",  64'(bus.core_start),  64'(vecs[i].e_start));
            check("all_done",    64'(bus.all_done),    64'(vecs[i].e_done));
            check("mem_we",      64'(bus.mem_we),      64'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                check("mem_addr",  64'(bus.mem_addr),  64'(WR_ADDR));
                check("mem_wdata", 64'(bus.mem_wdata), 64'(WR_DATA));
            end
            check("run_cycles",  64'(bus.run_cycles),  64'(vecs[i].e_run));
        end

        // reset the cycle after a read grant: the read is discarded, pointer restored
        vi = 100;
        cur_addr  = {12'h023, 12'h022, 12'h021, 12'h020};
        cur_wdata = '0;
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000); step();
        check("rst_done",  64'(bus.all_done),   64'd0);
        check("rst_run",   64'(bus.run_cycles), 64'd0);
        vi = 101;
        drive(0, 1, 4'b0000, 4'b0000, 4'b0000); step();
        check("restart_start", 64'(bus.core_start), 64'd1);
        vi = 102;
        drive(0, 1, 4'b0100, 4'b0000, 4'b0000); step();
        check("pre_gnt", 64'(bus.core_gnt),   64'b0100);
        check("pre_run", 64'(bus.run_cycles), 64'd1);
        vi = 103;
        drive(1, 1, 4'b0000, 4'b0000, 4'b0000); step();
        check("mid_rst_rvalid", 64'(bus.core_rvalid), 64'd0);
        check("mid_rst_start",  64'(bus.core_start),  64'd0);
        check("mid_rst_run",    64'(bus.run_cycles),  64'd0);
        vi = 104;
        drive(0, 0, 4'b0000, 4'b0000, 4'b0000); step();
        check("post_rst_rvalid", 64'(bus.core_rvalid), 64'd0);
        check("post_rst_idle",   64'(bus.core_start),  64'd0);
        vi = 105;
        drive(0, 1, 4'b0000, 4'b0000, 4'b0000); step();
        check("rerun_start", 64'(bus.core_start), 64'd1);
        vi = 106;
        drive(0, 1, 4'b1111, 4'b0000, 4'b0000); step();
        check("rerun_gnt0", 64'(bus.core_gnt), 64'b0001);
        vi = 107;
        drive(0, 1, 4'b1110, 4'b0000, 4'b0000); step();
        check("rerun_gnt1",   64'(bus.core_gnt),    64'b0010);
        check("rerun_rvalid", 64'(bus.core_rvalid), 64'b0001);
        check("rerun_rdata",  64'(bus.core_rdata),  64'(init_val(12'h020)));
        check("rerun_notdone", 64'(bus.all_done),   64'd0);
        vi = 108;
        drive(0, 1, 4'b0000, 4'b0000, 4'b0000); step();
        check("rerun_run", 64'(bus.run_cycles), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end
endmodule
